vector_lane_streamer: RTL and testbench
=======================================

Name: vector_lane_streamer

Overview:
- Vector register storage stage, directly downstream of the register-code decoder.
- Consumes the 4-bit vector register number (architectural registers 16-31 mapped to 0-15).
- Holds 16 vector registers of LANES elements each, with a single-cycle full-width write port.
- Read port: a request is snapshotted and streamed lane-serially, with a valid/ready handshake, to the lane execution/VGA datapath.

Parameters:
- LANES, 4, elements per vector register; power of two, 2..16.
- LANE_W, 8, bits per element.
- IDX_W, log2(LANES) (2 at default), width of LaneIndex; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- WriteEnable  in  1  write strobe.
- WriteVector  in  4  vector register number to write (0-15).
- WriteData  in  LANES*LANE_W  full vector; lane k = bits [k*LANE_W +: LANE_W].
- ReadValid  in  1  read request valid.
- ReadReady  out  1  streamer can accept a request this cycle.
- ReadVector  in  4  vector register number to read.
- LaneData  out  LANE_W  current element.
- LaneIndex  out  IDX_W  lane number of LaneData.
- LaneValid  out  1  LaneData/LaneIndex valid.
- LaneLast  out  1  high with the final lane (LANES-1).
- LaneReady  in  1  consumer accepts the current lane.

Behaviour:

Reset:
- When reset_n=0 at a rising edge: all 16 registers clear to 0, state goes to IDLE, and the snapshot buffer clears.
- After reset: LaneValid=0, LaneLast=0, LaneIndex=0, LaneData=0, ReadReady=1.
- Reset wins over every simultaneous write or handshake.
- Reset mid-stream aborts the stream; no further lanes are emitted.

Write:
- If WriteEnable=1 at an edge, reg[WriteVector] <= WriteData.
- Visible to reads accepted on the following edge or later, and through the same-edge bypass below.

State machine (IDLE, STREAM):
- IDLE: ReadReady=1, LaneValid=0.
  - On ReadValid=1, the edge captures snapshot <= reg[ReadVector], lane counter <= 0, state -> STREAM.
- Same-edge bypass: if WriteEnable=1 and WriteVector==ReadVector in the accept cycle, the snapshot takes WriteData (write-first).
- STREAM: LaneValid=1, LaneIndex=counter, LaneData=snapshot lane[counter], LaneLast=(counter==LANES-1).
  - LaneReady=0: all lane outputs hold stable (no drop, no advance).
  - LaneReady=1 and not last: counter increments.
  - LaneReady=1 and last: the stream completes.
- ReadReady in STREAM equals LaneLast & LaneReady, allowing back-to-back requests.
  - Accepted then: new snapshot, counter=0, remain in STREAM, no bubble.
  - Not accepted then: -> IDLE.
- The snapshot is isolated: writes to the register being streamed do not alter lanes already in flight.

Latency and throughput:
- Request accepted at edge N: lane 0 valid in the cycle following edge N.
- Lane k is presented k cycles later with no stalls.
- Full vector takes LANES cycles; sustained throughput is 1 lane/cycle.

Other rules:
- ReadValid while ReadReady=0 is ignored; the requester must hold it.
- ReadVector/WriteVector are always 4-bit, so every index is legal and there is no out-of-range case.
- No arithmetic on data; the counter wraps only via the explicit last-lane reset to 0.

Test Plan:
1. Reset: reset_n=0 for 2 cycles -> LaneValid=0, ReadReady=1. Read reg 5 -> lanes 0,0,0,0 with LaneIndex 0..3 and LaneLast only on index 3.
2. Write then read: write reg 3 = 0x44332211, then read reg 3 next cycle with LaneReady=1 -> LaneData 0x11,0x22,0x33,0x44 on 4 consecutive cycles, lane 0 one cycle after accept.
3. Back-pressure: stream reg 3 with LaneReady=0 for 3 cycles at lane 1 -> LaneData=0x22, LaneIndex=1 held stable; then 0x33, 0x44 resume; ReadReady=0 throughout the stall.
4. Bypass and isolation:
   - Same edge: write reg 7 = 0xDDCCBBAA and accept read reg 7 -> streams AA,BB,CC,DD.
   - Mid-stream write to reg 7 = 0 -> remaining lanes still CC,DD.
5. Back-to-back: hold ReadValid with reg 3 then reg 7 -> 8 valid lanes with no gap; LaneLast on cycles 4 and 8.
6. Reset mid-stream: reset_n=0 at lane 2 -> LaneValid=0 next cycle, reg 3 reads back zeros, ReadReady=1.

Source files
------------

// File: rtl/vector_lane_streamer.sv
// Vector register file (16 x LANES elements) with a snapshotting, lane-serial read streamer.
// A full-width write port updates one register per cycle; reads stream one element per cycle.
module vector_lane_streamer #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      WriteEnable,
    input  logic [3:0]                WriteVector,
    input  logic [LANES*LANE_W-1:0]   WriteData,
    input  logic                      ReadValid,
    output logic                      ReadReady,
    input  logic [3:0]                ReadVector,
    output logic [LANE_W-1:0]         LaneData,
    output logic [$clog2(LANES)-1:0]  LaneIndex,
    output logic                      LaneValid,
    output logic                      LaneLast,
    input  logic                      LaneReady
);

    localparam int unsigned IDX_W    = $clog2(LANES);
    localparam int unsigned DATA_W   = LANES * LANE_W;
    localparam int unsigned NUM_REGS = 16;

    typedef enum logic {
        IDLE,
        STREAM
    } streamState;

    streamState           state;
    streamState           stateNext;
    logic [IDX_W-1:0]     laneCount;
    logic [IDX_W-1:0]     laneCountNext;
    logic                 snapLoad;
    logic                 isLast;
    logic [DATA_W-1:0]    snapshot;
    logic [DATA_W-1:0]    readSource;
    logic [DATA_W-1:0]    regFile [NUM_REGS];
    logic [LANE_W-1:0]    snapLanes [LANES];

    // Write-first bypass: a same-edge write to the requested register feeds the snapshot.
    always_comb begin
        readSource = regFile[ReadVector];
        if (WriteEnable && (WriteVector == ReadVector)) begin
            readSource = WriteData;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            snapLanes[k] = snapshot[k*LANE_W +: LANE_W];
        end
    end

    assign isLast = (state == STREAM) && (laneCount == IDX_W'(LANES - 1));

    // Next-state, counter advance and request acceptance.
    always_comb begin
        stateNext     = state;
        laneCountNext = laneCount;
        snapLoad      = 1'b0;
        ReadReady     = 1'b0;
        unique case (state)
            IDLE: begin
                ReadReady = 1'b1;
                if (ReadValid) begin
                    snapLoad      = 1'b1;
                    laneCountNext = '0;
                    stateNext     = STREAM;
                end
            end
            STREAM: begin
                if (LaneReady) begin
                    if (isLast) begin
                        ReadReady     = 1'b1;
                        laneCountNext = '0;
                        if (ReadValid) begin
                            snapLoad = 1'b1;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        laneCountNext = laneCount + IDX_W'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            laneCount <= '0;
            snapshot  <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regFile[r] <= '0;
            end
        end else begin
            state     <= stateNext;
            laneCount <= laneCountNext;
            if (snapLoad) begin
                snapshot <= readSource;
            end
            if (WriteEnable) begin
                regFile[WriteVector] <= WriteData;
            end
        end
    end

    // Lane outputs decode purely from registered state.
    assign LaneValid = (state == STREAM);
    assign LaneIndex = laneCount;
    assign LaneLast  = isLast;
    assign LaneData  = LaneValid ? snapLanes[laneCount] : '0;

endmodule

// File: tb/tb_vector_lane_streamer.sv
// Directed self-checking bench for vector_lane_streamer: reset, write/read, stalls,
// bypass/isolation, back-to-back requests and mid-stream reset.
module tb_vector_lane_streamer;

    logic        clk;
    logic        reset_n;
    logic        WriteEnable;
    logic [3:0]  WriteVector;
    logic [31:0] WriteData;
    logic        ReadValid;
    logic        ReadReady;
    logic [3:0]  ReadVector;
    logic [7:0]  LaneData;
    logic [1:0]  LaneIndex;
    logic        LaneValid;
    logic        LaneLast;
    logic        LaneReady;

    int vectors;
    int errors;

    vector_lane_streamer #(.LANES(4), .LANE_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .WriteEnable(WriteEnable),
        .WriteVector(WriteVector),
        .WriteData  (WriteData),
        .ReadValid  (ReadValid),
        .ReadReady  (ReadReady),
        .ReadVector (ReadVector),
        .LaneData   (LaneData),
        .LaneIndex  (LaneIndex),
        .LaneValid  (LaneValid),
        .LaneLast   (LaneLast),
        .LaneReady  (LaneReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkLane(input string tag, input int idx, input logic [7:0] data, input logic last);
        chk($sformatf("%s.valid", tag), 32'(LaneValid), 32'(1));
        chk($sformatf("%s.index", tag), 32'(LaneIndex), 32'(idx));
        chk($sformatf("%s.data", tag),  32'(LaneData),  32'(data));
        chk($sformatf("%s.last", tag),  32'(LaneLast),  32'(last));
    endtask

    task automatic chkIdle(input string tag);
        chk($sformatf("%s.valid", tag), 32'(LaneValid), 32'(0));
        chk($sformatf("%s.ready", tag), 32'(ReadReady), 32'(1));
        chk($sformatf("%s.index", tag), 32'(LaneIndex), 32'(0));
        chk($sformatf("%s.last", tag),  32'(LaneLast),  32'(0));
    endtask

    logic [7:0] expLanes [4];

    initial begin
        vectors     = 0;
        errors      = 0;
        reset_n     = 1'b0;
        WriteEnable = 1'b0;
        WriteVector = 4'd0;
        WriteData   = 32'h0;
        ReadValid   = 1'b0;
        ReadVector  = 4'd0;
        LaneReady   = 1'b1;

        // 1: reset for two cycles, then read zeroed reg 5
        step();
        step();
        chkIdle("rst");
        chk("rst.data", 32'(LaneData), 32'h0);
        reset_n    = 1'b1;
        ReadValid  = 1'b1;
        ReadVector = 4'd5;
        chk("r5.accept", 32'(ReadReady), 32'(1));
        step();
        ReadValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chkLane($sformatf("r5.l%0d", k), k, 8'h00, k == 3);
            chk($sformatf("r5.rdy%0d", k), 32'(ReadReady), 32'(k == 3));
            step();
        end
        chkIdle("r5.done");

        // 2: write reg 3 then read it the following cycle
        WriteEnable = 1'b1;
        WriteVector = 4'd3;
        WriteData   = 32'h44332211;
        step();
        WriteEnable = 1'b0;
        ReadValid   = 1'b1;
        ReadVector  = 4'd3;
        step();
        ReadValid   = 1'b0;
        expLanes[0] = 8'h11; expLanes[1] = 8'h22; expLanes[2] = 8'h33; expLanes[3] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            chkLane($sformatf("r3.l%0d", k), k, expLanes[k], k == 3);
            step();
        end
        chkIdle("r3.done");

        // 3: back-pressure at lane 1 for three cycles
        ReadValid  = 1'b1;
        ReadVector = 4'd3;
        step();
        ReadValid = 1'b0;
        chkLane("bp.l0", 0, 8'h11, 1'b0);
        step();
        LaneReady = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chkLane($sformatf("bp.hold%0d", s), 1, 8'h22, 1'b0);
            chk($sformatf("bp.rdy%0d", s), 32'(ReadReady), 32'(0));
            step();
        end
        LaneReady = 1'b1;
        chkLane("bp.l1", 1, 8'h22, 1'b0);
        step();
        chkLane("bp.l2", 2, 8'h33, 1'b0);
        step();
        chkLane("bp.l3", 3, 8'h44, 1'b1);
        step();
        chkIdle("bp.done");

        // 4: same-edge bypass on reg 7, then mid-stream overwrite does not reach snapshot
        WriteEnable = 1'b1;
        WriteVector = 4'd7;
        WriteData   = 32'hDDCCBBAA;
        ReadValid   = 1'b1;
        ReadVector  = 4'd7;
        step();
        WriteEnable = 1'b0;
        ReadValid   = 1'b0;
        chkLane("byp.l0", 0, 8'hAA, 1'b0);
        step();
        chkLane("byp.l1", 1, 8'hBB, 1'b0);
        WriteEnable = 1'b1;
        WriteVector = 4'd7;
        WriteData   = 32'h0;
        step();
        WriteEnable = 1'b0;
        chkLane("iso.l2", 2, 8'hCC, 1'b0);
        step();
        chkLane("iso.l3", 3, 8'hDD, 1'b1);
        step();
        chkIdle("iso.done");

        // 5: back-to-back reg 3 then reg 7 (now zero) with ReadValid held
        ReadValid  = 1'b1;
        ReadVector = 4'd3;
        step();
        for (int k = 0; k < 3; k++) begin
            chkLane($sformatf("b2b.a%0d", k), k, expLanes[k], 1'b0);
            chk($sformatf("b2b.ardy%0d", k), 32'(ReadReady), 32'(0));
            step();
        end
        ReadVector = 4'd7;
        chkLane("b2b.a3", 3, 8'h44, 1'b1);
        chk("b2b.handoff", 32'(ReadReady), 32'(1));
        step();
        ReadValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chkLane($sformatf("b2b.b%0d", k), k, 8'h00, k == 3);
            step();
        end
        chkIdle("b2b.done");

        // 6: reset during lane 2 aborts stream and clears registers
        ReadValid  = 1'b1;
        ReadVector = 4'd3;
        step();
        ReadValid = 1'b0;
        step();
        step();
        chkLane("mrst.l2", 2, 8'h33, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chkIdle("mrst.after");
        chk("mrst.data", 32'(LaneData), 32'h0);
        step();
        chkIdle("mrst.quiet");
        ReadValid  = 1'b1;
        ReadVector = 4'd3;
        step();
        ReadValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chkLane($sformatf("mrst.r3l%0d", k), k, 8'h00, k == 3);
            step();
        end
        chkIdle("mrst.done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
